// File: rtl/instr_fetch_unit.sv
// Fetch unit: issues one outstanding imem request at a time from the PC and buffers responses for decode.
// Latency: request 1 cycle after IDLE, response pushed the cycle it arrives, head visible the next cycle.
// Backpressure: stops requesting when the buffer would be full; pc_hold keeps the PC still until a request is accepted.
module instr_fetch_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_hold,
  input  logic             flush,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst_data,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             drop;
  logic [WIDTH-1:0] req_pc;

  logic [WIDTH-1:0] mem_pc   [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;

  logic hs;
  logic push;
  logic pop;
  logic room_nxt;

  // Request is presented only in REQ; the address follows the PC, which is held until the handshake.
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = imem_req_valid ? pc_in : '0;
  assign hs             = imem_req_valid && imem_req_ready;

  // PC steps exactly once per accepted request, or loads the redirect target on flush.
  assign pc_hold = !(hs || flush);

  // A response is kept only if it belongs to a request issued since the last redirect.
  assign push       = (state == WAIT) && imem_rsp_valid && !drop && !flush;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !flush;
  assign inst_data  = mem_data[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];

  // Occupancy after this cycle's push/pop; flush empties the buffer outright.
  always_comb begin
    count_nxt = count;
    if (flush) count_nxt = '0;
    else       count_nxt = count + CW'(push) - CW'(pop);
  end

  assign room_nxt = (count_nxt < CW'(DEPTH));

  // Next-state: a new request is only started when its response is guaranteed a slot.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!flush && (count < CW'(DEPTH))) state_nxt = REQ;
      REQ: begin
        if (hs)         state_nxt = WAIT;
        else if (flush) state_nxt = IDLE;
      end
      WAIT: begin
        if (imem_rsp_valid) state_nxt = (room_nxt && !flush) ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the drop flag that marks the outstanding response as stale after a redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      drop   <= 1'b0;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        req_pc <= imem_req_addr;
        drop   <= flush;
      end else if (state == WAIT) begin
        if (imem_rsp_valid) drop <= 1'b0;
        else if (flush)     drop <= 1'b1;
      end
    end
  end

  // Instruction buffer: circular storage of {pc, instruction}, pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]   <= req_pc;
        mem_data[wr_ptr] <= imem_rsp_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

endmodule
